// File: rtl/alarm_trigger_if.sv
// Bus between the timekeeper/user controls and the alarm trigger.
// Clock and reset remain plain ports on the alarm_trigger module.
`timescale 1ns/1ps
interface alarm_trigger_if;
  logic       tick_sec;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       set_valid;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       alarm_en;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       reach_alarm;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       set_err;

  modport master (
    output tick_sec, cur_hour, cur_min, cur_sec, set_valid, set_hour, set_min,
    output alarm_en, snooze_btn, dismiss_btn,
    input  reach_alarm, ringing, snoozing, snooze_cnt, alarm_hour, alarm_min, set_err
  );

  modport slave (
    input  tick_sec, cur_hour, cur_min, cur_sec, set_valid, set_hour, set_min,
    input  alarm_en, snooze_btn, dismiss_btn,
    output reach_alarm, ringing, snoozing, snooze_cnt, alarm_hour, alarm_min, set_err
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm-match and ringing controller: compares the stored alarm time on each second tick,
// fires reach_alarm, and tracks the ring / snooze / dismiss sequence.
`timescale 1ns/1ps
module alarm_trigger #(
  parameter int unsigned RING_CYCLES = 67108864,
  parameter int unsigned SNOOZE_SEC  = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input logic            clk_sys,
  input logic            rst,
  alarm_trigger_if.slave bus
);

  localparam int unsigned     RingW      = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
  localparam logic [RingW-1:0] RingLast  = RingW'(RING_CYCLES - 1);
  localparam logic [9:0]      SnoozeLoad = 10'(SNOOZE_SEC);
  localparam logic [2:0]      SnoozeMax  = 3'(MAX_SNOOZE);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StRinging = 2'd2;
  localparam logic [1:0] StSnooze  = 2'd3;

  logic [1:0]       r_state,      w_state;
  logic [RingW-1:0] r_ring_cnt,   w_ring_cnt;
  logic [9:0]       r_snz_timer,  w_snz_timer;
  logic [2:0]       r_snooze_cnt, w_snooze_cnt;
  logic [4:0]       r_alarm_hour, w_alarm_hour;
  logic [5:0]       r_alarm_min,  w_alarm_min;
  logic             r_reach,      w_reach;
  logic             r_set_err,    w_set_err;

  logic w_set_ok;
  logic w_match;

  assign w_set_ok = bus.set_valid && (bus.set_hour <= 5'd23) && (bus.set_min <= 6'd59);

  // Only a tick at second zero can match, so each alarm minute fires at most once.
  assign w_match = bus.tick_sec && (bus.cur_sec == 6'd0) &&
                   (bus.cur_hour == r_alarm_hour) && (bus.cur_min == r_alarm_min);

  always_comb begin
    w_state      = r_state;
    w_ring_cnt   = r_ring_cnt;
    w_snz_timer  = r_snz_timer;
    w_snooze_cnt = r_snooze_cnt;
    w_alarm_hour = r_alarm_hour;
    w_alarm_min  = r_alarm_min;
    w_reach      = 1'b0;
    w_set_err    = bus.set_valid && !w_set_ok;

    if (w_set_ok) begin
      w_alarm_hour = bus.set_hour;
      w_alarm_min  = bus.set_min;
    end

    if (!bus.alarm_en) begin
      w_state      = StIdle;
      w_ring_cnt   = '0;
      w_snz_timer  = '0;
      w_snooze_cnt = '0;
    end else if (w_set_ok) begin
      // An accepted set aborts any ring/snooze and suppresses a same-cycle match.
      w_state     = StArmed;
      w_ring_cnt  = '0;
      w_snz_timer = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state = StArmed;
        end
        StArmed: begin
          if (w_match) begin
            w_state      = StRinging;
            w_reach      = 1'b1;
            w_ring_cnt   = '0;
            w_snooze_cnt = '0;
          end
        end
        StRinging: begin
          if (bus.dismiss_btn) begin
            w_state    = StArmed;
            w_ring_cnt = '0;
          end else if (bus.snooze_btn && (r_snooze_cnt < SnoozeMax)) begin
            w_state      = StSnooze;
            w_snooze_cnt = r_snooze_cnt + 3'd1;
            w_snz_timer  = SnoozeLoad;
            w_ring_cnt   = '0;
          end else if (r_ring_cnt == RingLast) begin
            w_state    = StArmed;
            w_ring_cnt = '0;
          end else begin
            w_ring_cnt = r_ring_cnt + RingW'(1);
          end
        end
        StSnooze: begin
          if (bus.dismiss_btn) begin
            w_state     = StArmed;
            w_snz_timer = '0;
          end else if (bus.tick_sec) begin
            if (r_snz_timer <= 10'd1) begin
              w_state     = StRinging;
              w_reach     = 1'b1;
              w_ring_cnt  = '0;
              w_snz_timer = '0;
            end else begin
              w_snz_timer = r_snz_timer - 10'd1;
            end
          end
        end
        default: begin
          w_state = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state      <= StIdle;
      r_ring_cnt   <= '0;
      r_snz_timer  <= '0;
      r_snooze_cnt <= '0;
      r_alarm_hour <= '0;
      r_alarm_min  <= '0;
      r_reach      <= 1'b0;
      r_set_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_ring_cnt   <= w_ring_cnt;
      r_snz_timer  <= w_snz_timer;
      r_snooze_cnt <= w_snooze_cnt;
      r_alarm_hour <= w_alarm_hour;
      r_alarm_min  <= w_alarm_min;
      r_reach      <= w_reach;
      r_set_err    <= w_set_err;
    end
  end

  assign bus.reach_alarm = r_reach;
  assign bus.ringing     = (r_state == StRinging);
  assign bus.snoozing    = (r_state == StSnooze);
  assign bus.snooze_cnt  = r_snooze_cnt;
  assign bus.alarm_hour  = r_alarm_hour;
  assign bus.alarm_min   = r_alarm_min;
  assign bus.set_err     = r_set_err;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with short ring/snooze parameters.
`timescale 1ns/1ps
module tb_alarm_trigger;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_ring;

  alarm_trigger_if bus_if ();

  alarm_trigger #(
    .RING_CYCLES (16),
    .SNOOZE_SEC  (2),
    .MAX_SNOOZE  (1)
  ) u_dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus_if)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    bus_if.cur_hour = 5'(h);
    bus_if.cur_min  = 6'(m);
    bus_if.cur_sec  = 6'(s);
    bus_if.tick_sec = 1'b1;
    step();
    bus_if.tick_sec = 1'b0;
  endtask

  task automatic set_time(input int h, input int m);
    bus_if.set_hour  = 5'(h);
    bus_if.set_min   = 6'(m);
    bus_if.set_valid = 1'b1;
    step();
    bus_if.set_valid = 1'b0;
  endtask

  task automatic press(input logic snz, input logic dis);
    bus_if.snooze_btn  = snz;
    bus_if.dismiss_btn = dis;
    step();
    bus_if.snooze_btn  = 1'b0;
    bus_if.dismiss_btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.tick_sec    = 1'b0;
    bus_if.cur_hour    = '0;
    bus_if.cur_min     = '0;
    bus_if.cur_sec     = '0;
    bus_if.set_valid   = 1'b0;
    bus_if.set_hour    = '0;
    bus_if.set_min     = '0;
    bus_if.alarm_en    = 1'b0;
    bus_if.snooze_btn  = 1'b0;
    bus_if.dismiss_btn = 1'b0;

    step();
    step();
    check("rst_reach", bus_if.reach_alarm, 0);
    check("rst_ringing", bus_if.ringing, 0);
    check("rst_snoozing", bus_if.snoozing, 0);
    check("rst_snooze_cnt", bus_if.snooze_cnt, 0);
    check("rst_hour", bus_if.alarm_hour, 0);
    check("rst_min", bus_if.alarm_min, 0);
    check("rst_set_err", bus_if.set_err, 0);
    rst = 1'b0;

    set_time(7, 30);
    check("set_hour", bus_if.alarm_hour, 7);
    check("set_min", bus_if.alarm_min, 30);
    check("set_ok_no_err", bus_if.set_err, 0);
    bus_if.alarm_en = 1'b1;
    step();

    // Basic fire and timeout
    tick_at(7, 29, 0);
    check("wrong_min_no_fire", bus_if.reach_alarm, 0);
    tick_at(7, 30, 0);
    check("fire_reach", bus_if.reach_alarm, 1);
    check("fire_ringing", bus_if.ringing, 1);
    n_ring = 0;
    while (bus_if.ringing && n_ring < 40) begin
      n_ring++;
      step();
      if (n_ring == 1) check("reach_single_pulse", bus_if.reach_alarm, 0);
    end
    check("ring_length", n_ring, 16);

    // Dismiss, then no re-fire within the minute
    tick_at(7, 30, 0);
    check("fire2_reach", bus_if.reach_alarm, 1);
    step();
    step();
    press(1'b0, 1'b1);
    check("dismiss_ringing", bus_if.ringing, 0);
    tick_at(7, 30, 1);
    check("no_refire_reach", bus_if.reach_alarm, 0);
    check("no_refire_ringing", bus_if.ringing, 0);

    // Snooze replay
    tick_at(7, 30, 0);
    check("fire3_reach", bus_if.reach_alarm, 1);
    press(1'b1, 1'b0);
    check("snooze_snoozing", bus_if.snoozing, 1);
    check("snooze_cnt1", bus_if.snooze_cnt, 1);
    check("snooze_ringing", bus_if.ringing, 0);
    tick_at(7, 30, 5);
    check("snz_tick1_reach", bus_if.reach_alarm, 0);
    check("snz_tick1_snoozing", bus_if.snoozing, 1);
    tick_at(7, 30, 6);
    check("refire_reach", bus_if.reach_alarm, 1);
    check("refire_ringing", bus_if.ringing, 1);
    check("refire_snoozing", bus_if.snoozing, 0);
    press(1'b1, 1'b0);
    check("max_snooze_cnt", bus_if.snooze_cnt, 1);
    check("max_snooze_ringing", bus_if.ringing, 1);
    check("max_snooze_snoozing", bus_if.snoozing, 0);
    press(1'b0, 1'b1);
    check("dismiss2_ringing", bus_if.ringing, 0);

    // Invalid set values
    set_time(24, 0);
    check("bad_hour_err", bus_if.set_err, 1);
    check("bad_hour_hold_h", bus_if.alarm_hour, 7);
    check("bad_hour_hold_m", bus_if.alarm_min, 30);
    step();
    check("set_err_pulse", bus_if.set_err, 0);
    set_time(23, 60);
    check("bad_min_err", bus_if.set_err, 1);
    check("bad_min_hold_h", bus_if.alarm_hour, 7);
    check("bad_min_hold_m", bus_if.alarm_min, 30);

    // Snooze and dismiss together: dismiss wins
    tick_at(7, 30, 0);
    check("fire4_reach", bus_if.reach_alarm, 1);
    press(1'b1, 1'b1);
    check("both_ringing", bus_if.ringing, 0);
    check("both_snoozing", bus_if.snoozing, 0);
    check("both_snooze_cnt", bus_if.snooze_cnt, 0);

    // Disable during snooze
    tick_at(7, 30, 0);
    press(1'b1, 1'b0);
    check("pre_dis_snoozing", bus_if.snoozing, 1);
    bus_if.alarm_en = 1'b0;
    step();
    check("dis_snoozing", bus_if.snoozing, 0);
    check("dis_ringing", bus_if.ringing, 0);
    check("dis_snooze_cnt", bus_if.snooze_cnt, 0);
    check("dis_reach", bus_if.reach_alarm, 0);
    bus_if.alarm_en = 1'b1;
    step();

    // Reset while ringing
    tick_at(7, 30, 0);
    step();
    check("pre_rst_ringing", bus_if.ringing, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ringing", bus_if.ringing, 0);
    check("midrst_reach", bus_if.reach_alarm, 0);
    check("midrst_hour", bus_if.alarm_hour, 0);
    check("midrst_min", bus_if.alarm_min, 0);
    check("midrst_snooze_cnt", bus_if.snooze_cnt, 0);

    // Set coinciding with a matching tick suppresses the match
    step();
    bus_if.cur_hour  = 5'd0;
    bus_if.cur_min   = 6'd0;
    bus_if.cur_sec   = 6'd0;
    bus_if.tick_sec  = 1'b1;
    set_time(8, 15);
    bus_if.tick_sec  = 1'b0;
    check("setmatch_reach", bus_if.reach_alarm, 0);
    check("setmatch_ringing", bus_if.ringing, 0);
    check("setmatch_hour", bus_if.alarm_hour, 8);
    tick_at(8, 15, 0);
    check("new_time_fire", bus_if.reach_alarm, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
